qsys_sysid_reader: RTL and testbench
====================================

// Module: qsys_sysid_reader
// PURPOSE
//  Avalon-MM read master that interrogates the system-ID slave after reset/on request.
//  Reads word 0 (system ID) then word 1 (timestamp), compares both against expected values,
//  reports pass/fail/timeout. Sits between the Nios-less boot sequencer and the sysid
//  control_slave, so hardware can refuse to start the Ethernet datapath on an image mismatch.
// PARAMETERS
//  EXPECTED_ID     32'd4660        value required at word address 0
//  EXPECTED_TS     32'd1631301145  value required at word address 1
//  TIMEOUT_CYCLES  16'd255         max cycles per transaction (wait + data) before abort; >=1
//  USE_RDVALID     0               0: fixed latency 0, data sampled when read & !waitrequest;
//                                  1: data sampled on readdatavalid
// PORTS
//  clock              in   1   system clock; all logic rising-edge
//  reset              in   1   synchronous, active-high reset
//  start              in   1   1-cycle pulse: begin check; ignored while busy
//  busy               out  1   high from accepted start until done pulse
//  done               out  1   1-cycle pulse when check completes (pass, fail or timeout)
//  id_ok              out  1   sticky: id_value == EXPECTED_ID (valid when !busy)
//  ts_ok              out  1   sticky: ts_value == EXPECTED_TS (valid when !busy)
//  timeout            out  1   sticky: last check aborted on timeout
//  id_value           out  32  captured word 0
//  ts_value           out  32  captured word 1
//  avm_address        out  1   word address to slave
//  avm_read           out  1   read request
//  avm_waitrequest    in   1   slave stall (tie 0 for sysid)
//  avm_readdata       in   32  slave read data
//  avm_readdatavalid  in   1   used only when USE_RDVALID=1
// BEHAVIOUR
//  Reset: state IDLE; busy, done, id_ok, ts_ok, timeout, avm_read, avm_address = 0;
//   id_value, ts_value = 0. Reset mid-transaction drops avm_read next edge, no done pulse.
//  FSM: IDLE -start-> REQ_ID -accept-> (WAIT_ID if USE_RDVALID) -> REQ_TS -> (WAIT_TS) -> FIN -> IDLE
//   IDLE: on start: clear id_ok/ts_ok/timeout, busy=1, go REQ_ID.
//   REQ_x: avm_read=1, avm_address=0 (ID) / 1 (TS), held stable while avm_waitrequest=1.
//    Accept = avm_read & !avm_waitrequest. USE_RDVALID=0: capture avm_readdata at accept.
//    USE_RDVALID=1: drop avm_read after accept, go WAIT_x, capture on readdatavalid.
//    Readdatavalid in WAIT_x only; any readdatavalid outside WAIT_x is ignored.
//   FIN: done=1 for one cycle, busy=0 next cycle, state IDLE. id_ok/ts_ok updated at capture.
//  Latency (sysid, waitrequest=0, USE_RDVALID=0): start at cycle N -> read ID at N+1,
//   read TS at N+2, done at N+3. Exactly one read per word; no back-to-back overlap.
//  Timeout: per-transaction counter cleared on entry to REQ_x; increments each cycle in
//   REQ_x/WAIT_x; on reaching TIMEOUT_CYCLES without capture: avm_read=0, timeout=1,
//   skip remaining reads, go FIN. Capture and expiry same cycle: capture wins.
//  start while busy: ignored. start in same cycle as done: ignored (accepted from IDLE only).
//  Compare is full 32-bit equality; no masking.
// STRUCTURE
//  Shared package qsys_sysid_pkg: state enum (IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FIN),
//   SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1, default EXPECTED_ID/EXPECTED_TS constants.
//  One sub-module: qsys_timeout_ctr (clear, enable, limit -> expired), 16-bit saturating.
//  FSM, capture registers and comparators stay in this module.
// TESTING
//  1 Sysid model (addr?1631301145:4660), USE_RDVALID=0, start -> reads addr 0 then 1,
//    done at start+3, id_ok=1, ts_ok=1, timeout=0.
//  2 Model returns TS 0x00000000 -> done, id_ok=1, ts_ok=0, ts_value=0.
//  3 waitrequest held 3 cycles per read -> address/read stable while stalled, done at
//    start+9, both ok.
//  4 waitrequest stuck 1, TIMEOUT_CYCLES=8 -> avm_read drops after 8 cycles, timeout=1,
//    id_ok=0, one done pulse, no TS read issued.
//  5 USE_RDVALID=1, readdatavalid 2 cycles after accept, stray readdatavalid in IDLE ->
//    correct capture, stray ignored, both ok.
//  6 reset asserted while in REQ_TS; start pulsed while busy -> outputs to reset values,
//    no done; busy-start causes no second sequence.

Source files
------------

// File: rtl/qsys_sysid_pkg.sv
// Shared types and constants for the system-ID boot check.
package qsys_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_ID,
    WAIT_ID,
    REQ_TS,
    WAIT_TS,
    FIN
  } state_e;

  localparam logic        SYSID_ADDR_ID          = 1'b0;
  localparam logic        SYSID_ADDR_TS          = 1'b1;
  localparam logic [31:0] DEFAULT_EXPECTED_ID    = 32'd4660;
  localparam logic [31:0] DEFAULT_EXPECTED_TS    = 32'd1631301145;
  localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd255;

  // States in which a read transaction is outstanding and the timeout runs.
  function automatic logic is_active(input state_e s);
    return (s == REQ_ID) || (s == WAIT_ID) || (s == REQ_TS) || (s == WAIT_TS);
  endfunction

endpackage

// File: rtl/qsys_timeout_ctr.sv
// Per-transaction cycle counter; expired_o flags the limit-th enabled cycle.
module qsys_timeout_ctr (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic [15:0] limit_i,
  output logic        expired_o
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 16'd0;
    end else if (enable_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds completed cycles, so the current cycle is number count_q+1.
  assign expired_o = enable_i && (({1'b0, count_q} + 17'd1) >= {1'b0, limit_i});

endmodule

// File: rtl/qsys_sysid_reader.sv
// Avalon-MM read master: fetches sysid word 0 (ID) and word 1 (timestamp), compares
// both with the expected image values and reports pass/fail/timeout.
module qsys_sysid_reader
  import qsys_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter bit          USE_RDVALID    = 1'b0
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        id_ok_o,
  output logic        ts_ok_o,
  output logic        timeout_o,
  output logic [31:0] id_value_o,
  output logic [31:0] ts_value_o,
  output logic        avm_address_o,
  output logic        avm_read_o,
  input  logic        avm_waitrequest_i,
  input  logic [31:0] avm_readdata_i,
  input  logic        avm_readdatavalid_i
);

  state_e      state_q, state_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        accept;
  logic        expired;
  logic        tmr_clear;
  logic        tmr_enable;

  assign avm_read_o    = (state_q == REQ_ID) || (state_q == REQ_TS);
  assign avm_address_o = (state_q == REQ_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == FIN);
  assign accept        = avm_read_o & ~avm_waitrequest_i;

  always_comb begin
    state_d    = state_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          state_d   = REQ_ID;
        end
      end
      REQ_ID: begin
        // An accept in the expiry cycle still counts: capture wins over timeout.
        if (accept) begin
          if (USE_RDVALID) begin
            state_d = WAIT_ID;
          end else begin
            id_value_d = avm_readdata_i;
            id_ok_d    = (avm_readdata_i == EXPECTED_ID);
            state_d    = REQ_TS;
          end
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = FIN;
        end
      end
      WAIT_ID: begin
        if (avm_readdatavalid_i) begin
          id_value_d = avm_readdata_i;
          id_ok_d    = (avm_readdata_i == EXPECTED_ID);
          state_d    = REQ_TS;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = FIN;
        end
      end
      REQ_TS: begin
        if (accept) begin
          if (USE_RDVALID) begin
            state_d = WAIT_TS;
          end else begin
            ts_value_d = avm_readdata_i;
            ts_ok_d    = (avm_readdata_i == EXPECTED_TS);
            state_d    = FIN;
          end
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = FIN;
        end
      end
      WAIT_TS: begin
        if (avm_readdatavalid_i) begin
          ts_value_d = avm_readdata_i;
          ts_ok_d    = (avm_readdata_i == EXPECTED_TS);
          state_d    = FIN;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  // Each word gets a fresh budget, including a direct REQ_ID -> REQ_TS hop.
  assign tmr_enable = is_active(state_q);
  assign tmr_clear  = (state_d != state_q) && ((state_d == REQ_ID) || (state_d == REQ_TS));

  qsys_timeout_ctr u_timeout_ctr (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_enable),
    .limit_i   (TIMEOUT_CYCLES),
    .expired_o (expired)
  );

  assign id_ok_o    = id_ok_q;
  assign ts_ok_o    = ts_ok_q;
  assign timeout_o  = timeout_q;
  assign id_value_o = id_value_q;
  assign ts_value_o = ts_value_q;

endmodule

// File: tb/tb_qsys_sysid_reader.sv
// Scoreboard bench: two readers (fixed latency and readdatavalid) against sysid slave models.
module tb_qsys_sysid_reader;

  localparam logic [31:0] EXP_ID = 32'd4660;
  localparam logic [31:0] EXP_TS = 32'd1631301145;
  localparam int          TMO    = 8;

  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        tmo;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          done_cyc;
    int          n_id;
    int          n_ts;
    logic        ts_seen;
  } exp_t;

  exp_t exp_q_a[$];
  exp_t exp_q_b[$];

  int cmp = 0;
  int err = 0;
  int cyc = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: fixed latency
  logic        reset_a, start_a, busy_a, done_a, id_ok_a, ts_ok_a, tmo_a, addr_a, read_a;
  logic        wr_a, rdv_a;
  logic [31:0] idv_a, tsv_a, rdata_a;
  logic [31:0] id_word_a, ts_word_a, mid_a, mts_a;
  int          stall_a, left_a, acc_id_a, acc_ts_a;
  logic        stuck_a, fresh_a, hold_addr_a, ts_seen_a;

  // Instance B: readdatavalid
  logic        reset_b, start_b, busy_b, done_b, id_ok_b, ts_ok_b, tmo_b, addr_b, read_b;
  logic        wr_b, rdv_b;
  logic [31:0] idv_b, tsv_b, rdata_b;
  logic [31:0] id_word_b, ts_word_b, mid_b, mts_b;
  int          stall_b, left_b, lat_b, cd_b, acc_id_b, acc_ts_b;
  logic        fresh_b, rv_addr_b, stray_en_b, ts_seen_b;

  qsys_sysid_reader #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(16'd8), .USE_RDVALID(1'b0)
  ) dut_a (
    .clock_i(clk), .reset_i(reset_a), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .id_ok_o(id_ok_a), .ts_ok_o(ts_ok_a), .timeout_o(tmo_a), .id_value_o(idv_a),
    .ts_value_o(tsv_a), .avm_address_o(addr_a), .avm_read_o(read_a),
    .avm_waitrequest_i(wr_a), .avm_readdata_i(rdata_a), .avm_readdatavalid_i(rdv_a)
  );

  qsys_sysid_reader #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(16'd8), .USE_RDVALID(1'b1)
  ) dut_b (
    .clock_i(clk), .reset_i(reset_b), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .id_ok_o(id_ok_b), .ts_ok_o(ts_ok_b), .timeout_o(tmo_b), .id_value_o(idv_b),
    .ts_value_o(tsv_b), .avm_address_o(addr_b), .avm_read_o(read_b),
    .avm_waitrequest_i(wr_b), .avm_readdata_i(rdata_b), .avm_readdatavalid_i(rdv_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    cmp++;
    if (act !== req) begin
      err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Sysid slave A: word mux on address, programmable waitrequest stall per read.
  assign rdata_a = addr_a ? ts_word_a : id_word_a;
  always @(negedge clk) begin
    if (!read_a) begin
      wr_a    = 1'b0;
      fresh_a = 1'b1;
    end else begin
      if (addr_a) ts_seen_a = 1'b1;
      if (fresh_a) begin
        left_a      = stall_a;
        fresh_a     = 1'b0;
        hold_addr_a = addr_a;
      end else begin
        chk("a_addr_stable", 64'(addr_a), 64'(hold_addr_a));
      end
      if (stuck_a || left_a > 0) begin
        wr_a = 1'b1;
        if (left_a > 0) left_a--;
      end else begin
        wr_a    = 1'b0;
        fresh_a = 1'b1;
        if (addr_a) acc_ts_a++;
        else acc_id_a++;
      end
    end
  end

  // Sysid slave B: waitrequest stall, then data on readdatavalid lat_b cycles after accept.
  always @(negedge clk) begin
    rdv_b   = 1'b0;
    rdata_b = $urandom;
    if (cd_b > 0) begin
      cd_b--;
      if (cd_b == 0) begin
        rdv_b   = 1'b1;
        rdata_b = rv_addr_b ? ts_word_b : id_word_b;
      end
    end else if (!busy_b && stray_en_b && ($urandom_range(0, 2) == 0)) begin
      rdv_b = 1'b1;
    end
    if (!read_b) begin
      wr_b    = 1'b0;
      fresh_b = 1'b1;
    end else begin
      if (addr_b) ts_seen_b = 1'b1;
      if (fresh_b) begin
        left_b  = stall_b;
        fresh_b = 1'b0;
      end
      if (left_b > 0) begin
        wr_b = 1'b1;
        left_b--;
      end else begin
        wr_b      = 1'b0;
        fresh_b   = 1'b1;
        cd_b      = lat_b;
        rv_addr_b = addr_b;
        if (addr_b) acc_ts_b++;
        else acc_id_b++;
      end
    end
  end

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (exp_q_a.size() == 0) begin
        chk("a_unexpected_done", 64'(done_a), 64'd0);
      end else begin
        exp_t e;
        e = exp_q_a.pop_front();
        chk("a_id_ok", 64'(id_ok_a), 64'(e.id_ok));
        chk("a_ts_ok", 64'(ts_ok_a), 64'(e.ts_ok));
        chk("a_timeout", 64'(tmo_a), 64'(e.tmo));
        chk("a_id_value", 64'(idv_a), 64'(e.idv));
        chk("a_ts_value", 64'(tsv_a), 64'(e.tsv));
        chk("a_done_cycle", 64'(cyc), 64'(e.done_cyc));
        chk("a_id_reads", 64'(acc_id_a), 64'(e.n_id));
        chk("a_ts_reads", 64'(acc_ts_a), 64'(e.n_ts));
        chk("a_ts_requested", 64'(ts_seen_a), 64'(e.ts_seen));
        chk("a_read_low_at_done", 64'(read_a), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (done_b === 1'b1) begin
      if (exp_q_b.size() == 0) begin
        chk("b_unexpected_done", 64'(done_b), 64'd0);
      end else begin
        exp_t e;
        e = exp_q_b.pop_front();
        chk("b_id_ok", 64'(id_ok_b), 64'(e.id_ok));
        chk("b_ts_ok", 64'(ts_ok_b), 64'(e.ts_ok));
        chk("b_timeout", 64'(tmo_b), 64'(e.tmo));
        chk("b_id_value", 64'(idv_b), 64'(e.idv));
        chk("b_ts_value", 64'(tsv_b), 64'(e.tsv));
        chk("b_done_cycle", 64'(cyc), 64'(e.done_cyc));
        chk("b_id_reads", 64'(acc_id_b), 64'(e.n_id));
        chk("b_ts_reads", 64'(acc_ts_b), 64'(e.n_ts));
      end
    end
  end

  function automatic logic [31:0] pick(input logic [31:0] good);
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return $urandom;
    if (r == 1) return good ^ (32'd1 << $urandom_range(0, 31));
    if (r == 2) return 32'd0;
    return good;
  endfunction

  task automatic chk_reset_state_a(input string tag);
    chk({tag, "_a_ctrl"}, 64'({busy_a, done_a, id_ok_a, ts_ok_a, tmo_a, read_a, addr_a}), 64'd0);
    chk({tag, "_a_values"}, {idv_a, tsv_a}, 64'd0);
  endtask

  task automatic run_a(input logic [31:0] idw, input logic [31:0] tsw, input int s,
                       input bit stuck, input bit busy_start, input bit start_on_done);
    exp_t e;
    int   n;
    id_word_a = idw; ts_word_a = tsw; stall_a = s; stuck_a = stuck;
    acc_id_a = 0; acc_ts_a = 0; ts_seen_a = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    if (stuck) begin
      e.id_ok = 1'b0; e.ts_ok = 1'b0; e.tmo = 1'b1; e.idv = mid_a; e.tsv = mts_a;
      e.n_id = 0; e.n_ts = 0; e.ts_seen = 1'b0; e.done_cyc = cyc + TMO + 1;
    end else begin
      mid_a = idw; mts_a = tsw;
      e.id_ok = (idw == EXP_ID); e.ts_ok = (tsw == EXP_TS); e.tmo = 1'b0;
      e.idv = idw; e.tsv = tsw; e.n_id = 1; e.n_ts = 1; e.ts_seen = 1'b1;
      e.done_cyc = cyc + 2 * (s + 1) + 1;
    end
    exp_q_a.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
    chk("a_busy_after_start", 64'(busy_a), 64'd1);
    n = 0;
    while (busy_a && n < 200) begin
      start_a = (busy_start && n == 1) || (start_on_done && done_a);
      @(negedge clk);
      n++;
    end
    start_a = 1'b0;
    chk("a_finished_in_bound", 64'(busy_a), 64'd0);
    $display("A run id=%08h ts=%08h stall=%0d stuck=%0d -> id_ok=%0d ts_ok=%0d tmo=%0d",
             idw, tsw, s, stuck, id_ok_a, ts_ok_a, tmo_a);
  endtask

  task automatic run_b(input logic [31:0] idw, input logic [31:0] tsw, input int s, input int lat);
    exp_t e;
    int   n;
    id_word_b = idw; ts_word_b = tsw; stall_b = s; lat_b = lat;
    acc_id_b = 0; acc_ts_b = 0;
    @(negedge clk);
    start_b = 1'b1;
    mid_b = idw; mts_b = tsw;
    e.id_ok = (idw == EXP_ID); e.ts_ok = (tsw == EXP_TS); e.tmo = 1'b0;
    e.idv = idw; e.tsv = tsw; e.n_id = 1; e.n_ts = 1; e.ts_seen = 1'b1;
    e.done_cyc = cyc + 2 * (s + 1 + lat) + 1;
    exp_q_b.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (busy_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b_finished_in_bound", 64'(busy_b), 64'd0);
    repeat (3) @(negedge clk);
    $display("B run id=%08h ts=%08h stall=%0d lat=%0d -> id_ok=%0d ts_ok=%0d idv=%08h",
             idw, tsw, s, lat, id_ok_b, ts_ok_b, idv_b);
  endtask

  initial begin
    int n;
    reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    wr_a = 1'b0; rdv_a = 1'b0; wr_b = 1'b0; rdv_b = 1'b0; rdata_b = 32'd0;
    id_word_a = EXP_ID; ts_word_a = EXP_TS; id_word_b = EXP_ID; ts_word_b = EXP_TS;
    stall_a = 0; left_a = 0; stuck_a = 1'b0; fresh_a = 1'b1; hold_addr_a = 1'b0;
    acc_id_a = 0; acc_ts_a = 0; ts_seen_a = 1'b0; mid_a = 32'd0; mts_a = 32'd0;
    stall_b = 0; left_b = 0; lat_b = 1; cd_b = 0; fresh_b = 1'b1; rv_addr_b = 1'b0;
    acc_id_b = 0; acc_ts_b = 0; ts_seen_b = 1'b0; mid_b = 32'd0; mts_b = 32'd0;
    stray_en_b = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state_a("reset");
    chk("reset_b_ctrl", 64'({busy_b, done_b, id_ok_b, ts_ok_b, tmo_b, read_b, addr_b}), 64'd0);
    chk("reset_b_values", {idv_b, tsv_b}, 64'd0);
    reset_a = 1'b0; reset_b = 1'b0;
    repeat (2) @(negedge clk);

    run_a(EXP_ID, EXP_TS, 0, 1'b0, 1'b0, 1'b0);   // nominal
    run_a(EXP_ID, 32'd0, 0, 1'b0, 1'b0, 1'b1);    // bad timestamp, start on done
    run_a(EXP_ID, EXP_TS, 3, 1'b0, 1'b1, 1'b0);   // stalls, start while busy
    run_a(EXP_ID, EXP_TS, 0, 1'b1, 1'b0, 1'b1);   // waitrequest stuck -> timeout
    run_a(EXP_ID, EXP_TS, 7, 1'b0, 1'b0, 1'b0);   // accept in expiry cycle
    run_b(EXP_ID, EXP_TS, 0, 2);

    // Reset while the TS read is stalled: no done, outputs back to reset values.
    id_word_a = EXP_ID; ts_word_a = EXP_TS; stall_a = 6; stuck_a = 1'b0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n = 0;
    while (!(read_a && addr_a) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("a_reached_req_ts", 64'(read_a && addr_a), 64'd1);
    reset_a = 1'b1;
    @(negedge clk);
    chk_reset_state_a("midreset");
    reset_a = 1'b0; mid_a = 32'd0; mts_a = 32'd0;
    repeat (5) @(negedge clk);
    chk("a_idle_after_reset", 64'(busy_a), 64'd0);

    for (int i = 0; i < 25; i++) begin
      run_a(pick(EXP_ID), pick(EXP_TS), $urandom_range(0, 7), ($urandom_range(0, 5) == 0),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 25; i++) begin
      int s;
      s = $urandom_range(0, 2);
      run_b(pick(EXP_ID), pick(EXP_TS), s, $urandom_range(1, 7 - s));
    end

    repeat (5) @(negedge clk);
    chk("a_queue_drained", 64'(exp_q_a.size()), 64'd0);
    chk("b_queue_drained", 64'(exp_q_b.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
